sipo16_loader: RTL and testbench

Serial-to-parallel front end that assembles a 16-bit word from a one-bit serial stream and delivers it through a valid/ready handshake. It sits directly upstream of the team's 16-bit D-register stage. par_out is the D input of that register, and par_valid/par_ready gate when the register captures. The block holds its own output word, so the downstream register can stall without losing data, up to the overrun rule below.

---
 rtl/sipo16_loader.sv | 97 +++++++++
 tb/tb_sipo16_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo16_loader.sv
// Serial-to-parallel word assembler with a one-word output slot and valid/ready handoff.
// A word completing while the slot is still held is dropped and flagged on overrun.
module sipo16_loader #(
    parameter int unsigned WIDTH     = 16,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    input  logic             par_ready,
    output logic             overrun,
    output logic             busy
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    state_e           state;
    logic [WIDTH-1:0] shift_reg;
    logic [CntW-1:0]  count;

    logic [WIDTH-1:0] first_word;
    logic [WIDTH-1:0] shifted_word;
    logic             start_bit;
    logic             shift_bit;
    logic             word_done;
    logic             slot_free;

    always_comb begin
        first_word   = '0;
        shifted_word = '0;
        if (MSB_FIRST) begin
            first_word   = {{(WIDTH-1){1'b0}}, ser_in};
            shifted_word = {shift_reg[WIDTH-2:0], ser_in};
        end else begin
            first_word   = {ser_in, {(WIDTH-1){1'b0}}};
            shifted_word = {ser_in, shift_reg[WIDTH-1:1]};
        end
    end

    // frame_start wins in both states, so a resync simply restarts the word.
    always_comb begin
        start_bit = ser_valid && frame_start;
        shift_bit = ser_valid && !frame_start && (state == StShift);
        word_done = shift_bit && (count == LastCnt);
        slot_free = !par_valid || par_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            shift_reg <= '0;
            count     <= '0;
            par_out   <= '0;
            par_valid <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (par_valid && par_ready) begin
                par_valid <= 1'b0;
            end

            if (start_bit) begin
                shift_reg <= first_word;
                count     <= CntW'(1);
                state     <= StShift;
                busy      <= 1'b1;
            end else if (shift_bit) begin
                shift_reg <= shifted_word;
                if (word_done) begin
                    count <= '0;
                    state <= StIdle;
                    busy  <= 1'b0;
                    if (slot_free) begin
                        par_out   <= shifted_word;
                        par_valid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sipo16_loader.sv
// Drives MSB-first and LSB-first instances with one stream and checks both against a
// queue-based model of framing and output-slot occupancy.
module tb_sipo16_loader;

    logic        clk;
    logic        rst_n;
    logic        ser_in;
    logic        ser_valid;
    logic        frame_start;
    logic        par_ready;

    logic [15:0] m_par_out;
    logic        m_par_valid;
    logic        m_overrun;
    logic        m_busy;
    logic [15:0] l_par_out;
    logic        l_par_valid;
    logic        l_overrun;
    logic        l_busy;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: received bits of the current frame plus the output slot.
    bit          bits[$];
    logic [15:0] exp_m;
    logic [15:0] exp_l;
    logic        exp_valid;
    logic        exp_ov;
    logic        exp_busy;

    sipo16_loader #(.WIDTH(16), .MSB_FIRST(1'b1)) dut_msb (
        .clk        (clk),
        .rst_n      (rst_n),
        .ser_in     (ser_in),
        .ser_valid  (ser_valid),
        .frame_start(frame_start),
        .par_out    (m_par_out),
        .par_valid  (m_par_valid),
        .par_ready  (par_ready),
        .overrun    (m_overrun),
        .busy       (m_busy)
    );

    sipo16_loader #(.WIDTH(16), .MSB_FIRST(1'b0)) dut_lsb (
        .clk        (clk),
        .rst_n      (rst_n),
        .ser_in     (ser_in),
        .ser_valid  (ser_valid),
        .frame_start(frame_start),
        .par_out    (l_par_out),
        .par_valid  (l_par_valid),
        .par_ready  (par_ready),
        .overrun    (l_overrun),
        .busy       (l_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        bits.delete();
        exp_m     = '0;
        exp_l     = '0;
        exp_valid = 1'b0;
        exp_ov    = 1'b0;
        exp_busy  = 1'b0;
    endtask

    task automatic model_edge();
        logic        done;
        logic [15:0] w_m;
        logic [15:0] w_l;
        done = 1'b0;
        w_m  = '0;
        w_l  = '0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        exp_ov = 1'b0;
        if (ser_valid) begin
            if (frame_start) begin
                bits.delete();
                bits.push_back(ser_in);
            end else if (bits.size() != 0) begin
                bits.push_back(ser_in);
                if (bits.size() == 16) begin
                    for (int i = 0; i < 16; i++) begin
                        w_m[15-i] = bits[i];
                        w_l[i]    = bits[i];
                    end
                    bits.delete();
                    done = 1'b1;
                end
            end
        end
        if (done) begin
            if (!exp_valid || par_ready) begin
                exp_m     = w_m;
                exp_l     = w_l;
                exp_valid = 1'b1;
            end else begin
                exp_ov = 1'b1;
            end
        end else if (exp_valid && par_ready) begin
            exp_valid = 1'b0;
        end
        exp_busy = (bits.size() != 0);
    endtask

    task automatic check_all();
        chk("msb_par_out", m_par_out, exp_m);
        chk("msb_par_valid", 16'(m_par_valid), 16'(exp_valid));
        chk("msb_overrun", 16'(m_overrun), 16'(exp_ov));
        chk("msb_busy", 16'(m_busy), 16'(exp_busy));
        chk("lsb_par_out", l_par_out, exp_l);
        chk("lsb_par_valid", 16'(l_par_valid), 16'(exp_valid));
        chk("lsb_overrun", 16'(l_overrun), 16'(exp_ov));
        chk("lsb_busy", 16'(l_busy), 16'(exp_busy));
    endtask

    task automatic step(input logic v, input logic fs, input logic b, input logic rdy);
        ser_valid   = v;
        frame_start = fs;
        ser_in      = b;
        par_ready   = rdy;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Idle cycles carry random ser_in/frame_start, which ser_valid=0 must mask.
    task automatic send_word(input logic [15:0] w, input bit lsb_order, input bit gapped,
                             input logic rdy, input logic rdy_last);
        logic b;
        for (int i = 0; i < 16; i++) begin
            b = lsb_order ? w[i] : w[15-i];
            step(1'b1, (i == 0), b, (i == 15) ? rdy_last : rdy);
            if (gapped) begin
                step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     (i == 15) ? rdy_last : rdy);
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        ser_in      = 1'b0;
        ser_valid   = 1'b0;
        frame_start = 1'b0;
        par_ready   = 1'b0;
        model_reset();

        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("reset_par_out", m_par_out, 16'h0000);
        chk("reset_busy", 16'(m_busy), 16'h0000);
        rst_n = 1'b1;

        // Reset then word
        send_word(16'hA5C3, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t1_word", m_par_out, 16'hA5C3);
        chk("t1_valid", 16'(m_par_valid), 16'h0001);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t1_valid_drop", 16'(m_par_valid), 16'h0000);

        // Gapped input
        send_word(16'h1234, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t2_word", m_par_out, 16'h1234);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Back-pressure and overrun
        send_word(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_overrun", 16'(m_overrun), 16'h0001);
        chk("t3_held", m_par_out, 16'hFFFF);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_overrun_once", 16'(m_overrun), 16'h0000);
        chk("t3_still_valid", 16'(m_par_valid), 16'h0001);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_consumed", 16'(m_par_valid), 16'h0000);

        // Simultaneous consume and complete
        send_word(16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(16'hFF00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4_word", m_par_out, 16'hFF00);
        chk("t4_valid", 16'(m_par_valid), 16'h0001);
        chk("t4_no_overrun", 16'(m_overrun), 16'h0000);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Resync after 7 bits
        for (int i = 0; i < 7; i++) begin
            step(1'b1, (i == 0), 1'($urandom_range(0, 1)), 1'b1);
        end
        send_word(16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_word", m_par_out, 16'hBEEF);
        chk("t5_no_overrun", 16'(m_overrun), 16'h0000);

        // Async reset during bit 9 while BEEF is still held
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i == 0), 1'($urandom_range(0, 1)), 1'b0);
        end
        ser_valid   = 1'b1;
        frame_start = 1'b0;
        ser_in      = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("t5_rst_par_out", m_par_out, 16'h0000);
        chk("t5_rst_valid", 16'(m_par_valid), 16'h0000);
        chk("t5_rst_busy", 16'(m_busy), 16'h0000);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end
        chk("t5_no_word", 16'(m_par_valid), 16'h0000);

        // LSB-first
        send_word(16'h8001, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("t6_lsb_word", l_par_out, 16'h8001);
        chk("t6_msb_word", m_par_out, 16'h8001);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
